// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP window sequencer: FSM states,
// neighbour byte indices and the 3x3 fetch-slot numbering.
package lbp_pkg;

  localparam int LBP_CW = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_PRESENT,
    ST_ADVANCE,
    ST_DONE
  } state_e;

  // Neighbour k occupies win_nbr[8k+7:8k]
  localparam int NBR_TL = 0;
  localparam int NBR_T  = 1;
  localparam int NBR_TR = 2;
  localparam int NBR_L  = 3;
  localparam int NBR_R  = 4;
  localparam int NBR_BL = 5;
  localparam int NBR_B  = 6;
  localparam int NBR_BR = 7;

  // Column-major slot order, which is also the full-fetch read order
  typedef enum logic [3:0] {
    SLOT_LT, SLOT_LM, SLOT_LB,
    SLOT_MT, SLOT_MM, SLOT_MB,
    SLOT_RT, SLOT_RM, SLOT_RB
  } slot_e;

  function automatic logic [1:0] slot_col(input slot_e s);
    return 2'(int'(s) / 3);
  endfunction

  function automatic logic [1:0] slot_row(input slot_e s);
    return 2'(int'(s) % 3);
  endfunction

endpackage

// File: rtl/lbp_window_regs.sv
// 3x3 pixel store (columns L, M, R; rows top to bottom) with slot write,
// left shift of the columns and packed centre/neighbour outputs.
module lbp_window_regs
  import lbp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_slot,
  input  logic [7:0]  wr_data,
  input  logic        shift_en,
  output logic [7:0]  center,
  output logic [63:0] nbr
);

  logic [7:0] px [3][3];  // [col][row]
  logic [1:0] wr_col;
  logic [1:0] wr_row;

  assign wr_col = slot_col(slot_e'(wr_slot));
  assign wr_row = slot_row(slot_e'(wr_slot));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          px[c][r] <= 8'd0;
        end
      end
    end else if (wr_en) begin
      px[wr_col][wr_row] <= wr_data;
    end else if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        px[0][r] <= px[1][r];
        px[1][r] <= px[2][r];
      end
    end
  end

  assign center = px[1][1];

  always_comb begin
    nbr = '0;
    nbr[8*NBR_TL +: 8] = px[0][0];
    nbr[8*NBR_T  +: 8] = px[1][0];
    nbr[8*NBR_TR +: 8] = px[2][0];
    nbr[8*NBR_L  +: 8] = px[0][1];
    nbr[8*NBR_R  +: 8] = px[2][1];
    nbr[8*NBR_BL +: 8] = px[0][2];
    nbr[8*NBR_B  +: 8] = px[1][2];
    nbr[8*NBR_BR +: 8] = px[2][2];
  end

endmodule

// File: rtl/lbp_window_sequencer.sv
// Raster-scans the image interior, fetches each 3x3 window from gray memory
// and hands it to the LBP datapath. LBP_WINDOW_REUSE_EN enables column reuse.
module lbp_window_sequencer
  import lbp_pkg::*;
#(
  parameter int CW = LBP_CW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            gray_ready,
  output logic            gray_req,
  output logic [2*CW-1:0] gray_addr,
  input  logic [7:0]      gray_data,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [2*CW-1:0] win_addr,
  output logic [7:0]      win_center,
  output logic [63:0]     win_nbr,
  output logic            finish,
  output logic [2:0]      dbg_state
);

  // Handshake: a window transfers on a cycle where win_valid && win_ready;
  // win_valid and all win_* stay stable until that transfer.

  localparam logic [CW-1:0] POS_MAX = CW'((1 << CW) - 2);
  localparam logic [CW-1:0] POS_ONE = CW'(1);

  state_e         state;
  slot_e          slot;
  slot_e          wr_slot;
  slot_e          first_slot;
  logic           wr_en;
  logic           shift_en;
  logic           last_pos;
  logic [CW-1:0]  row, col;
  logic [CW-1:0]  next_row, next_col;

  function automatic logic [2*CW-1:0] fetch_addr(input logic [CW-1:0] r,
                                                 input logic [CW-1:0] c,
                                                 input slot_e s);
    logic [CW-1:0] ar;
    logic [CW-1:0] ac;
    ar = r + CW'(slot_row(s)) - POS_ONE;
    ac = c + CW'(slot_col(s)) - POS_ONE;
    return {ar, ac};
  endfunction

  assign last_pos  = (row == POS_MAX) && (col == POS_MAX);
  assign win_addr  = {row, col};
  assign dbg_state = state;

  always_comb begin
    next_row = row;
    next_col = col + POS_ONE;
    if (col == POS_MAX) begin
      next_row = row + POS_ONE;
      next_col = POS_ONE;
    end
  end

`ifdef LBP_WINDOW_REUSE_EN
  // Mid-row windows keep L/M from the previous position and read only R
  assign first_slot = (next_col != POS_ONE) ? SLOT_RT : SLOT_LT;
  assign shift_en   = (state == ST_ADVANCE) && !last_pos && (next_col != POS_ONE);
`else
  assign first_slot = SLOT_LT;
  assign shift_en   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      row       <= POS_ONE;
      col       <= POS_ONE;
      slot      <= SLOT_LT;
      wr_slot   <= SLOT_LT;
      wr_en     <= 1'b0;
      gray_req  <= 1'b0;
      gray_addr <= '0;
      win_valid <= 1'b0;
      finish    <= 1'b0;
    end else begin
      // Read data returns one cycle after its request; track which slot it fills
      wr_en   <= gray_req;
      wr_slot <= slot;
      case (state)
        ST_IDLE: begin
          if (gray_ready) begin
            state     <= ST_FETCH;
            slot      <= SLOT_LT;
            gray_req  <= 1'b1;
            gray_addr <= fetch_addr(row, col, SLOT_LT);
          end
        end
        ST_FETCH: begin
          if (slot == SLOT_RB) begin
            state    <= ST_CAPTURE;
            gray_req <= 1'b0;
          end else begin
            slot      <= slot_e'(slot + 4'd1);
            gray_addr <= fetch_addr(row, col, slot_e'(slot + 4'd1));
          end
        end
        ST_CAPTURE: begin
          state     <= ST_PRESENT;
          win_valid <= 1'b1;
        end
        ST_PRESENT: begin
          if (win_ready) begin
            state     <= ST_ADVANCE;
            win_valid <= 1'b0;
          end
        end
        ST_ADVANCE: begin
          if (last_pos) begin
            state  <= ST_DONE;
            finish <= 1'b1;
          end else begin
            state     <= ST_FETCH;
            row       <= next_row;
            col       <= next_col;
            slot      <= first_slot;
            gray_req  <= 1'b1;
            gray_addr <= fetch_addr(next_row, next_col, first_slot);
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  lbp_window_regs u_regs (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_slot  (wr_slot),
    .wr_data  (gray_data),
    .shift_en (shift_en),
    .center   (win_center),
    .nbr      (win_nbr)
  );

endmodule

// File: tb/tb_lbp_window_sequencer.sv
// Scoreboard bench for lbp_window_sequencer on a 16x16 image; expected
// windows are queued at scan start and popped on each accepted window.
module tb_lbp_window_sequencer;
  import lbp_pkg::*;

  localparam int CW   = 4;
  localparam int MAXP = (1 << CW) - 2;
  localparam int NW   = MAXP * MAXP;
  localparam int W    = 2*CW + 8 + 64;
`ifdef LBP_WINDOW_REUSE_EN
  localparam int INC_READS   = 3;
  localparam int READS_TOTAL = MAXP * (9 + (MAXP - 1) * 3);
`else
  localparam int INC_READS   = 9;
  localparam int READS_TOTAL = NW * 9;
`endif

  logic            clk;
  logic            reset;
  logic            gray_ready;
  logic            gray_req;
  logic [2*CW-1:0] gray_addr;
  logic [7:0]      gray_data;
  logic            win_valid;
  logic            win_ready;
  logic [2*CW-1:0] win_addr;
  logic [7:0]      win_center;
  logic [63:0]     win_nbr;
  logic            finish;
  logic [2:0]      dbg_state;

  lbp_window_sequencer #(.CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_addr   (win_addr),
    .win_center (win_center),
    .win_nbr    (win_nbr),
    .finish     (finish),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  always @(posedge clk) gray_data <= mem[gray_addr];

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int reads = 0;
  int win_reads = 0;
  int accepts = 0;
  int last_acc_cyc = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_win(input int r, input int c);
    int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [63:0] n;
    logic [7:0]  a;
    n = '0;
    for (int k = 0; k < 8; k++) begin
      a = 8'(((r + dr[k]) << CW) + (c + dc[k]));
      n[8*k +: 8] = mem[a];
    end
    a = 8'((r << CW) + c);
    return {CW'(r), CW'(c), mem[a], n};
  endfunction

  task automatic push_scan(input bit skip_first);
    for (int r = 1; r <= MAXP; r++) begin
      for (int c = 1; c <= MAXP; c++) begin
        if (!(skip_first && r == 1 && c == 1)) exp_q.push_back(model_win(r, c));
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (!reset) begin
      if (gray_req) begin
        reads++;
        win_reads++;
      end
      if (win_valid && win_ready) begin
        got = {win_addr, win_center, win_nbr};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_window got=%0h exp=none", got);
        end else begin
          exp = exp_q.pop_front();
          check("window", got, exp);
        end
        if (win_addr == {4'd2, 4'd1}) check("wrap_full_reads", W'(win_reads), W'(9));
        if (win_addr == {4'd2, 4'd2}) check("inc_reads", W'(win_reads), W'(INC_READS));
        if (win_addr == {4'd5, 4'd8}) check("post_stall_reads", W'(win_reads), W'(INC_READS));
        win_reads = 0;
        accepts++;
        last_acc_cyc = cyc;
      end
    end
  end

  // ---------------- win_ready driver (stall on one window) ----------------
  int stall_left = 0;
  int stall_err = 0;
  logic [2*CW-1:0] stall_addr = {4'd5, 4'd7};
  logic [W-1:0] stall_snap;

  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (win_valid && win_addr == stall_addr && stall_left > 0) begin
        if (stall_left == 20) stall_snap = {win_addr, win_center, win_nbr};
        else if (stall_snap !== {win_addr, win_center, win_nbr}) stall_err++;
        if (gray_req) stall_err++;
        win_ready = 1'b0;
        stall_left--;
      end else begin
        if (stall_left > 0 && stall_left < 20 && !win_valid) stall_err++;
        win_ready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_gray_req"},   W'(gray_req),   W'(0));
    check({tag, "_gray_addr"},  W'(gray_addr),  W'(0));
    check({tag, "_win_valid"},  W'(win_valid),  W'(0));
    check({tag, "_win_addr"},   W'(win_addr),   W'(8'h11));
    check({tag, "_win_center"}, W'(win_center), W'(0));
    check({tag, "_win_nbr"},    W'(win_nbr),    W'(0));
    check({tag, "_finish"},     W'(finish),     W'(0));
    check({tag, "_state"},      W'(dbg_state),  W'(ST_IDLE));
  endtask

  task automatic clear_counts();
    reads = 0;
    win_reads = 0;
    accepts = 0;
  endtask

  task automatic wait_finish(input string tag);
    int n = 0;
    while (!finish && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finish_seen"}, W'(finish), W'(1));
    check({tag, "_finish_latency"}, W'(cyc - last_acc_cyc), W'(2));
    check({tag, "_accepts"}, W'(accepts), W'(NW));
    check({tag, "_reads"}, W'(reads), W'(READS_TOTAL));
    check({tag, "_queue_empty"}, W'(exp_q.size()), W'(0));
    repeat (5) @(negedge clk);
    check({tag, "_finish_sticky"}, W'(finish), W'(1));
    check({tag, "_done_valid"}, W'(win_valid), W'(0));
    check({tag, "_done_req"}, W'(gray_req), W'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int idx;
    int req_run;
    int n;
    reset = 1'b1;
    gray_ready = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'((a >> CW) + (a & ((1 << CW) - 1)));
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    reset = 1'b0;
    clear_counts();
    @(negedge clk);

    // Run 1: pixel = row+col, hand-checked first window, full scan
    exp_q.push_back({8'h11, 8'd2, 64'h0403020301020100});
    push_scan(1'b1);
    gray_ready = 1'b1;
    n = 0;
    while (!gray_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    gray_ready = 1'b0;
    idx = 0;
    req_run = 0;
    while (!win_valid && idx < 40) begin
      if (gray_req) req_run++;
      @(negedge clk);
      idx++;
    end
    check("first_req_cycles", W'(req_run), W'(9));
    check("first_valid_latency", W'(idx), W'(10));
    wait_finish("run1");

    // Run 2: scrambled pattern, stall on {5,7}
    reset = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = 8'((a * 73 + 19) ^ (a >> 3));
    @(negedge clk);
    exp_q.delete();
    clear_counts();
    reset = 1'b0;
    @(negedge clk);
    push_scan(1'b0);
    stall_left = 20;
    gray_ready = 1'b1;
    @(negedge clk);
    gray_ready = 1'b0;
    wait_finish("run2");
    check("stall_consumed", W'(stall_left), W'(0));
    check("stall_stable", W'(stall_err), W'(0));

    // Run 3: reset mid-fetch at {10,10}, then restart from {1,1}
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    clear_counts();
    reset = 1'b0;
    push_scan(1'b0);
    gray_ready = 1'b1;
    @(negedge clk);
    gray_ready = 1'b0;
    n = 0;
    while (!(win_addr == {4'd10, 4'd10} && gray_req) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reached_10_10", W'(win_addr), W'(8'hAA));
    @(negedge clk);
    check("mid_fetch", W'(gray_req), W'(1));
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    clear_counts();
    check_reset_vals("rst_mid");
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", W'(dbg_state), W'(ST_IDLE));
    push_scan(1'b0);
    gray_ready = 1'b1;
    @(negedge clk);
    gray_ready = 1'b0;
    wait_finish("run3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
